// File: rtl/drive_pkg.sv
// Shared constants and state type for the drive ramp path.
package drive_pkg;

  localparam logic [1:0] MODE_STOP  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_BOTH  = 2'b11;

  localparam int unsigned DEF_SPEED_W = 10;

  typedef enum logic [1:0] {
    RUN,
    DOWN,
    SWITCH
  } drive_state_t;

endpackage

// File: rtl/drive_tick.sv
// Free-running prescaler: one-cycle tick pulse every DIV clock cycles.
module drive_tick #(
  parameter int unsigned DIV = 100_000
) (
  input  logic c100MHz,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge c100MHz or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/drive_ramp.sv
// Slew-rate limiter for the motor {mode, speed} pair; any mode change ramps to 0 first.
// Optional emergency stop input enabled by defining DRIVE_RAMP_ESTOP_EN.
module drive_ramp
  import drive_pkg::*;
#(
  parameter int unsigned SPEED_W  = DEF_SPEED_W,
  parameter int unsigned TICK_DIV = 100_000,
  parameter int unsigned STEP     = 8
) (
  input  logic               c100MHz,
  input  logic               rst,
`ifdef DRIVE_RAMP_ESTOP_EN
  input  logic               estop,
`endif
  input  logic [1:0]         tgt_mode,
  input  logic [SPEED_W-1:0] tgt_speed,
  output logic [1:0]         mode,
  output logic [SPEED_W-1:0] speed,
  output logic               busy
);

  localparam logic [SPEED_W:0] STEP_X = (SPEED_W + 1)'(STEP);

  drive_state_t       state;
  logic               tick;
  logic [SPEED_W-1:0] eff_tgt;

  drive_tick #(.DIV(TICK_DIV)) u_tick (
    .c100MHz (c100MHz),
    .rst     (rst),
    .tick    (tick)
  );

  assign eff_tgt = (tgt_mode == MODE_STOP) ? '0 : tgt_speed;

  // One STEP toward tgt, computed one bit wider so neither direction can wrap.
  function automatic logic [SPEED_W-1:0] toward(input logic [SPEED_W-1:0] cur,
                                                input logic [SPEED_W-1:0] tgt);
    logic [SPEED_W:0] up;
    logic [SPEED_W:0] dn;
    up = {1'b0, cur} + STEP_X;
    dn = {1'b0, cur} - STEP_X;
    toward = cur;
    if (cur < tgt) begin
      toward = (up > {1'b0, tgt}) ? tgt : up[SPEED_W-1:0];
    end else if (cur > tgt) begin
      toward = (dn[SPEED_W] || (dn < {1'b0, tgt})) ? tgt : dn[SPEED_W-1:0];
    end
  endfunction

  always_ff @(posedge c100MHz or posedge rst) begin
    if (rst) begin
      state <= RUN;
      mode  <= MODE_STOP;
      speed <= '0;
    end
`ifdef DRIVE_RAMP_ESTOP_EN
    else if (estop) begin
      state <= RUN;
      mode  <= MODE_STOP;
      speed <= '0;
    end
`endif
    else begin
      case (state)
        RUN: begin
          if (tgt_mode != mode) begin
            state <= DOWN;
          end else if (tick) begin
            speed <= toward(speed, eff_tgt);
          end
        end
        DOWN: begin
          if (tgt_mode == mode) begin
            state <= RUN;
          end else if (speed == '0) begin
            state <= SWITCH;
          end else if (tick) begin
            speed <= toward(speed, '0);
          end
        end
        SWITCH: begin
          mode  <= tgt_mode;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    busy = (state != RUN) || (speed != eff_tgt);
`ifdef DRIVE_RAMP_ESTOP_EN
    if (estop) busy = 1'b1;
`endif
  end

endmodule

// File: tb/tb_drive_ramp.sv
// Self-checking bench for drive_ramp: directed vector table plus randomized run against a reference model.
module tb_drive_ramp;

  localparam int SW   = 10;
  localparam int TD   = 4;
  localparam int STP  = 8;
  localparam int SMAX = (1 << SW) - 1;

  logic          c100MHz = 1'b0;
  logic          rst     = 1'b1;
  logic [1:0]    tgt_mode  = 2'b00;
  logic [SW-1:0] tgt_speed = '0;
  logic [1:0]    mode;
  logic [SW-1:0] speed;
  logic          busy;
`ifdef DRIVE_RAMP_ESTOP_EN
  logic          estop = 1'b0;
`endif

  drive_ramp #(.SPEED_W(SW), .TICK_DIV(TD), .STEP(STP)) dut (
    .c100MHz   (c100MHz),
    .rst       (rst),
`ifdef DRIVE_RAMP_ESTOP_EN
    .estop     (estop),
`endif
    .tgt_mode  (tgt_mode),
    .tgt_speed (tgt_speed),
    .mode      (mode),
    .speed     (speed),
    .busy      (busy)
  );

  always #5 c100MHz = ~c100MHz;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain integers, cycle count since reset drives the tick.
  int m_mode, m_speed, m_cyc;
  bit m_changing;   // mode change requested, speed heading to zero
  bit m_swap;       // speed reached zero, new mode applied next edge

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit estop_now();
`ifdef DRIVE_RAMP_ESTOP_EN
    return estop;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int eff_now();
    return (tgt_mode == 2'b00) ? 0 : int'(tgt_speed);
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_speed = 0; m_cyc = 0; m_changing = 0; m_swap = 0;
  endtask

  task automatic model_edge();
    bit tk;
    tk = ((m_cyc % TD) == TD - 1);
    if (estop_now()) begin
      m_mode = 0; m_speed = 0; m_changing = 0; m_swap = 0;
    end else if (m_swap) begin
      m_mode = int'(tgt_mode); m_swap = 0;
    end else if (m_changing) begin
      if (int'(tgt_mode) == m_mode) m_changing = 0;
      else if (m_speed == 0) begin m_changing = 0; m_swap = 1; end
      else if (tk) m_speed = (m_speed > STP) ? m_speed - STP : 0;
    end else if (int'(tgt_mode) != m_mode) begin
      m_changing = 1;
    end else if (tk) begin
      m_speed = m_speed + clampi(eff_now() - m_speed, -STP, STP);
    end
    m_cyc++;
  endtask

  task automatic step();
    @(posedge c100MHz);
    model_edge();
    #1;
    chk("model_mode",  int'(mode),  m_mode);
    chk("model_speed", int'(speed), m_speed);
    chk("model_busy",  int'(busy),
        int'(estop_now() || m_changing || m_swap || (m_speed != eff_now())));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge c100MHz);
    #1 rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [1:0] tm;
    int         ts;
    int         n;
    logic [1:0] em;
    int         es;
    bit         eb;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // ramp up from reset, then step down, then clamp at zero
    tbl.push_back('{2'b11, 100,   1, 2'b00,   0, 1'b1});
    tbl.push_back('{2'b11, 100,   1, 2'b00,   0, 1'b1});
    tbl.push_back('{2'b11, 100,   1, 2'b11,   0, 1'b1});
    tbl.push_back('{2'b11, 100,   1, 2'b11,   8, 1'b1});
    tbl.push_back('{2'b11, 100,  44, 2'b11,  96, 1'b1});
    tbl.push_back('{2'b11, 100,   4, 2'b11, 100, 1'b0});
    tbl.push_back('{2'b11,  95,   4, 2'b11,  95, 1'b0});
    tbl.push_back('{2'b11,   0,   4, 2'b11,  87, 1'b1});
    tbl.push_back('{2'b11,   0,  40, 2'b11,   7, 1'b1});
    tbl.push_back('{2'b11,   0,   4, 2'b11,   0, 1'b0});
    tbl.push_back('{2'b11,   0,   4, 2'b11,   0, 1'b0});
    // aborted mode change
    tbl.push_back('{2'b11,  40,  20, 2'b11,  40, 1'b0});
    tbl.push_back('{2'b01,  40,   1, 2'b11,  40, 1'b1});
    tbl.push_back('{2'b01,  40,   3, 2'b11,  32, 1'b1});
    tbl.push_back('{2'b01,  40,   4, 2'b11,  24, 1'b1});
    tbl.push_back('{2'b11,  40,   1, 2'b11,  24, 1'b1});
    tbl.push_back('{2'b11,  40,   3, 2'b11,  32, 1'b1});
    tbl.push_back('{2'b11,  40,   4, 2'b11,  40, 1'b0});
    // full mode change 11 -> 01
    tbl.push_back('{2'b01,  40,   1, 2'b11,  40, 1'b1});
    tbl.push_back('{2'b01,  40,  19, 2'b11,   0, 1'b1});
    tbl.push_back('{2'b01,  40,   1, 2'b11,   0, 1'b1});
    tbl.push_back('{2'b01,  40,   1, 2'b01,   0, 1'b1});
    tbl.push_back('{2'b01,  40,   2, 2'b01,   8, 1'b1});
    // saturation at the top of the range
    tbl.push_back('{2'b01, 1020, 508, 2'b01, 1020, 1'b0});
    tbl.push_back('{2'b01, 1023,   4, 2'b01, 1023, 1'b0});
    tbl.push_back('{2'b01, 1000,   4, 2'b01, 1015, 1'b1});

    do_reset();
    chk("reset_mode",  int'(mode),  0);
    chk("reset_speed", int'(speed), 0);
    chk("reset_busy",  int'(busy),  0);

    foreach (tbl[i]) begin
      tgt_mode  = tbl[i].tm;
      tgt_speed = SW'(tbl[i].ts);
      repeat (tbl[i].n) step();
      chk($sformatf("vec%0d_mode", i),  int'(mode),  int'(tbl[i].em));
      chk($sformatf("vec%0d_speed", i), int'(speed), tbl[i].es);
      chk($sformatf("vec%0d_busy", i),  int'(busy),  int'(tbl[i].eb));
    end

    // asynchronous reset mid-ramp, observed before the next clock edge
    #3;
    tgt_mode = 2'b00; tgt_speed = '0;
    rst = 1'b1;
    #1;
    chk("async_rst_mode",  int'(mode),  0);
    chk("async_rst_speed", int'(speed), 0);
    chk("async_rst_busy",  int'(busy),  0);
    do_reset();

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(15) == 0) tgt_mode = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0:       tgt_speed = '0;
          1:       tgt_speed = SW'(SMAX - $urandom_range(STP));
          default: tgt_speed = SW'($urandom_range(SMAX));
        endcase
      end
`ifdef DRIVE_RAMP_ESTOP_EN
      estop = ($urandom_range(63) == 0);
`endif
      step();
    end

`ifdef DRIVE_RAMP_ESTOP_EN
    // emergency stop from speed 200, then ramp back up from zero
    do_reset();
    estop = 1'b0;
    tgt_mode = 2'b11; tgt_speed = SW'(200);
    begin
      int guard;
      guard = 0;
      while ((int'(speed) != 200) && (guard < 200)) begin step(); guard++; end
      chk("estop_reach200", int'(speed), 200);
    end
    estop = 1'b1;
    step();
    chk("estop_mode",  int'(mode),  0);
    chk("estop_speed", int'(speed), 0);
    chk("estop_busy",  int'(busy),  1);
    estop = 1'b0;
    repeat (3) step();
    chk("estop_release_mode", int'(mode), 3);
    begin
      int guard;
      guard = 0;
      while ((speed == '0) && (guard < TD)) begin step(); guard++; end
      chk("estop_first_step", int'(speed), STP);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
